// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and helpers shared by the serializer and the deserializer-side control
package serial_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // ceil(log2(v)); 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word capture, MSB-first serial output with last-bit strobe and optional idle gap
module piso_serializer
    import serial_pkg::*;
#(
    parameter int N   = 4,
    parameter int GAP = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] load_data,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         data_out,
    output logic         bit_valid,
    output logic         frame_done
);

    localparam int CW = clog2(N);
    localparam int GW = clog2(GAP + 1) > 0 ? clog2(GAP + 1) : 1;

    logic [1:0]    state;
    logic [N-1:0]  word;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gcnt;
    logic          last;
    logic          hs;

    // The last bit of a frame doubles as a load slot when frames run back to back
    assign last       = state == S_SEND && cnt == CW'(N - 1);
    assign load_ready = !reset && (state == S_IDLE || (GAP == 0 && last));
    assign hs         = load_valid && load_ready;
    assign data_out   = state == S_SEND && word[CW'(N - 1) - cnt];
    assign bit_valid  = state == S_SEND;
    assign frame_done = last;

    // Capture on handshake, step through the word, then idle out the gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            word  <= '0;
            cnt   <= '0;
            gcnt  <= '0;
        end else if (hs) begin
            word  <= load_data;
            cnt   <= '0;
            state <= S_SEND;
        end else if (state == S_SEND) begin
            if (last) begin
                state <= GAP > 0 ? S_GAP : S_IDLE;
                gcnt  <= GW'(GAP > 0 ? GAP - 1 : 0);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (state == S_GAP) begin
            if (gcnt == '0) state <= S_IDLE;
            else gcnt <= gcnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized frames on four configurations checked against a cycle-timeline model
module tb_piso_serializer;

    localparam int NS[4] = '{4, 4, 2, 8};
    localparam int GS[4] = '{0, 2, 0, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ld[4];
    logic       lv[4];
    logic       lr[4];
    logic       dout[4];
    logic       bv[4];
    logic       fd[4];
    logic [7:0] sr[4];
    int         checks = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        piso_serializer #(.N(NS[g]), .GAP(GS[g])) u_dut (
            .clk        (clk),
            .reset      (reset),
            .load_data  (ld[g][NS[g]-1:0]),
            .load_valid (lv[g]),
            .load_ready (lr[g]),
            .data_out   (dout[g]),
            .bit_valid  (bv[g]),
            .frame_done (fd[g])
        );
    end

    // Downstream shift registers fed from each serial line
    always @(posedge clk)
        for (int i = 0; i < 4; i++) sr[i] <= {sr[i][6:0], dout[i]};

    // Model: a handshake at cycle c puts bit j of the frame in cycle c+1+j; the block is ready again
    // at c+N (GAP==0) or c+N+GAP+1. Called at a falling edge with the target idle.
    task automatic run(input int d, input logic [7:0] words[$], input bit cont, input string tag);
        int n, gap, c, idx, fstart, next_ready, chk_at, k;
        logic [7:0] fw, cw, mask;
        logic eb, ebv, efd, erdy;
        n = NS[d];
        gap = GS[d];
        mask = 8'((1 << n) - 1);
        c = 0;
        idx = 0;
        fstart = -100;
        next_ready = 0;
        chk_at = -1;
        fw = '0;
        cw = '0;
        forever begin
            k = c - fstart;
            ebv = k >= 0 && k < n;
            eb = ebv ? fw[n-1-k] : 1'b0;
            efd = ebv && k == n - 1;
            erdy = c >= next_ready;
            checks += 4;
            if (dout[d] !== eb) begin fails++; $display("FAIL %s cyc %0d data_out got %b want %b", tag, c, dout[d], eb); end
            if (bv[d] !== ebv) begin fails++; $display("FAIL %s cyc %0d bit_valid got %b want %b", tag, c, bv[d], ebv); end
            if (fd[d] !== efd) begin fails++; $display("FAIL %s cyc %0d frame_done got %b want %b", tag, c, fd[d], efd); end
            if (lr[d] !== erdy) begin fails++; $display("FAIL %s cyc %0d load_ready got %b want %b", tag, c, lr[d], erdy); end
            if (c == chk_at) begin
                checks++;
                if ((sr[d] & mask) !== cw) begin fails++; $display("FAIL %s cyc %0d shift_q got %h want %h", tag, c, sr[d] & mask, cw); end
            end
            if (efd) begin chk_at = c + 1; cw = fw; end
            if (erdy && idx < words.size() && (cont || $urandom_range(0, 1) == 1)) begin
                lv[d] = 1'b1;
                ld[d] = words[idx] & mask;
                fw = words[idx] & mask;
                idx++;
                fstart = c + 1;
                next_ready = gap == 0 ? c + n : c + n + gap + 1;
            end else begin
                lv[d] = !erdy && $urandom_range(0, 1) == 1;
                ld[d] = 8'($urandom);
            end
            if (idx == words.size() && c > fstart + n + gap + 1) break;
            if (c >= 400) begin fails++; $display("FAIL %s timeout after %0d cycles", tag, c); break; end
            @(negedge clk);
            c++;
        end
        lv[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin lv[i] = 1'b0; ld[i] = '0; end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dout[i], bv[i], fd[i], lr[i]} !== 4'b0000)
                begin fails++; $display("FAIL reset dut%0d outputs got %b want 0000", i, {dout[i], bv[i], fd[i], lr[i]}); end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lr[i] !== 1'b1) begin fails++; $display("FAIL reset_release dut%0d load_ready got %b want 1", i, lr[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        run(0, '{8'b1011}, 1'b1, "basic");
    endtask

    task automatic test_back_to_back();
        run(0, '{8'b1011, 8'b0110}, 1'b1, "back_to_back");
        run(0, '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 1'b1, "b2b_rand");
    endtask

    task automatic test_gap();
        run(1, '{8'($urandom), 8'($urandom)}, 1'b1, "gap");
        run(1, '{8'($urandom), 8'($urandom), 8'($urandom)}, 1'b0, "gap_rand");
    endtask

    task automatic test_mid_reset();
        lv[0] = 1'b1;
        ld[0] = 8'h0F;
        @(negedge clk);
        lv[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout[0], bv[0]} !== 2'b11) begin fails++; $display("FAIL mid_reset bit2 got %b want 11", {dout[0], bv[0]}); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({dout[0], bv[0], fd[0], lr[0]} !== 4'b0000)
            begin fails++; $display("FAIL mid_reset abort got %b want 0000", {dout[0], bv[0], fd[0], lr[0]}); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({bv[0], lr[0]} !== 2'b01) begin fails++; $display("FAIL mid_reset release got %b want 01", {bv[0], lr[0]}); end
        run(0, '{8'b0001}, 1'b1, "after_reset");
    endtask

    task automatic test_ignored();
        run(0, '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 1'b0, "ignored");
    endtask

    task automatic test_width();
        run(2, '{8'b10}, 1'b1, "n2");
        run(2, '{8'($urandom), 8'($urandom), 8'($urandom)}, 1'b0, "n2_rand");
        run(3, '{8'hA5}, 1'b1, "n8");
        run(3, '{8'($urandom), 8'($urandom), 8'($urandom)}, 1'b1, "n8_b2b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gap();
        test_mid_reset();
        test_ignored();
        test_width();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage directly upstream of the N-bit serial-in shift register: accepts an N-bit word through a valid/ready handshake and drives it out MSB-first, one bit per clock, on a line that feeds the shift register's `data_in`. Bit order is chosen so that N clock edges after the first bit, the downstream register's `Q` equals the accepted word exactly. A frame strobe marks the last bit. A configurable idle gap between frames is supported.

## Interface
- `N`, default 4: word width; must be ≥ 2.
- `GAP`, default 0: idle cycles inserted after each frame; 0 allows back-to-back frames.
- `clk`  input  1  clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `load_data`  input  N  word to serialize; sampled only on handshake.
- `load_valid`  input  1  upstream offers `load_data`.
- `load_ready`  output  1  block can accept a word this cycle.
- `data_out`  output  1  serial bit; connects to the shift register's `data_in`.
- `bit_valid`  output  1  `data_out` carries a frame bit this cycle.
- `frame_done`  output  1  high during the cycle carrying bit 0 (the last bit) of a frame.

## Operation
- States: IDLE, SEND, GAP.
- Internal registers: N-bit `word` register, bit counter `cnt` of width clog2(N), gap counter of width clog2(GAP+1), minimum 1.
- **IDLE**
  - `load_ready`=1.
  - On `load_valid` && `load_ready`: `word`←`load_data`, `cnt`←0, go to SEND.
- **SEND**
  - `data_out`=`word[N-1-cnt]`, `bit_valid`=1.
  - If `cnt`<N-1: `cnt` increments.
  - If `cnt`==N-1: `frame_done`=1, and
    - GAP>0: go to GAP with gap counter←GAP-1.
    - GAP==0: `load_ready`=1. A handshake this cycle reloads `word`, resets `cnt` to 0 and stays in SEND. With no handshake, go to IDLE.
- **GAP**
  - `load_ready`=0, `bit_valid`=0, `data_out`=0.
  - Gap counter decrements; when it is 0, go to IDLE.
- `load_data` may change freely after acceptance; the captured word is unaffected.
- `load_ready` is combinational from state and `cnt`, and is forced to 0 while `reset` is high.
- Outside SEND: `data_out`=0, `bit_valid`=0, `frame_done`=0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `word`=0, `cnt`=0, gap counter=0. Outputs: `data_out`=0, `bit_valid`=0, `frame_done`=0, `load_ready`=0 while `reset` is asserted and 1 in the first cycle after release.
- Latency: handshake at edge k puts the MSB on `data_out` during cycle k+1. Bit i (MSB=N-1) appears in cycle k+N-i.
- Frame length is exactly N cycles of `bit_valid`. `frame_done` coincides with the last bit, in cycle k+N.
- With GAP==0 and continuous `load_valid`, throughput is one bit per cycle with no bubble: the next MSB follows the previous LSB in the very next cycle.
- With GAP>0, frames are separated by exactly GAP cycles in GAP plus one IDLE cycle before the next handshake is possible. The minimum frame-to-frame period is N+GAP+1.
- Reset during SEND or GAP aborts the frame at once. No `frame_done` is issued and the partial word is discarded.
- `load_valid` high during SEND (except the last bit with GAP==0) or during GAP is ignored and not queued.

## Structure
- Shared package/header `serial_pkg`: state encoding localparams `S_IDLE`, `S_SEND`, `S_GAP` and a `clog2` helper function. These are shared with the future deserializer-side control.
- Single module, no sub-module.

## Test plan
- **Basic frame:** N=4, GAP=0, reset then handshake `load_data`=4'b1011 → `data_out` 1,0,1,1 over four cycles, `bit_valid`=1 throughout, `frame_done` only on the 4th. The downstream shift register's `Q`=4'b1011 after the following edge.
- **Back-to-back:** `load_valid` held high with 4'b1011 then 4'b0110 → 8 consecutive valid bits 1,0,1,1,0,1,1,0. `load_ready` is high only in the IDLE cycle and the two last-bit cycles. `frame_done` pulses twice.
- **Gap:** N=4, GAP=2, two words queued → 4 bits, 2 cycles with `bit_valid`=0, 1 IDLE cycle with `load_ready`=1, then the next frame.
- **Reset mid-frame:** assert `reset` asynchronously after the 2nd bit of 4'b1111 → `data_out`, `bit_valid` and `load_ready` drop to 0 immediately. After release, a new word 4'b0001 serializes cleanly as 0,0,0,1.
- **Ignored input:** toggle `load_data` and `load_valid` during SEND → the current frame is unaffected and no extra frame is emitted.
- **Width sweep:** N=2 with word 2'b10, and N=8 with word 8'hA5 → correct MSB-first bit order, `frame_done` on bit N.
